// File: rtl/dma_cfg_pkg.sv
// Shared definitions for the DMA channel config path: FSM states, register
// offsets and the access-permission helpers used by the APB front end.
package dma_cfg_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [31:0] CH_CMD     = 32'h00;
  localparam logic [31:0] CH_STATUS  = 32'h04;
  localparam logic [31:0] WRKREGPTR  = 32'h88;
  localparam logic [31:0] RO_OFF0    = 32'h80;
  localparam logic [31:0] RO_OFF1    = 32'h8C;
  localparam logic [31:0] RO_OFF2    = 32'h90;

  // While a channel runs, only its command/status/work-pointer stay writable.
  function automatic logic is_writable_when_enabled(input logic [31:0] off);
    return (off == CH_CMD) || (off == CH_STATUS) || (off == WRKREGPTR);
  endfunction

  function automatic logic is_read_only(input logic [31:0] off);
    return (off == RO_OFF0) || (off == RO_OFF1) || (off == RO_OFF2);
  endfunction

endpackage

// File: rtl/apb_cfg_slave_if.sv
// APB3 completer bus bundle.
interface apb_cfg_slave_if #(parameter int WIDTH = 32);
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [WIDTH-1:0] PADDR;
  logic [WIDTH-1:0] PWDATA;
  logic [WIDTH-1:0] PRDATA;
  logic             PREADY;
  logic             PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_cfg_access_check.sv
// Combinational legality check of an APB access against the register map.
module apb_cfg_access_check
  import dma_cfg_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic [WIDTH-1:0] addr,
  input  logic             write,
  input  logic             ch_enabled,
  output logic             err
);
  logic [31:0] off;
  logic        misalign;
  logic        oor;

  assign off      = 32'(addr);
  assign misalign = addr[1:0] != 2'b00;
  assign oor      = (addr >> ADDR_W) != '0;

  assign err = misalign | oor
             | (write & is_read_only(off))
             | (write & ch_enabled & ~is_writable_when_enabled(off));
endmodule

// File: rtl/apb_cfg_slave.sv
// APB3 completer in front of the DMA channel register bank: one strobe per
// legal transfer, programmable wait states, PSLVERR for illegal accesses.
module apb_cfg_slave
  import dma_cfg_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             reset,
  apb_cfg_slave_if.slave   apb,
  input  logic             ch_enabled,
  input  logic [WIDTH-1:0] cfg_data_out,
  output logic             cfg_wr_en,
  output logic             cfg_rd_en,
  output logic [WIDTH-1:0] cfg_data_in,
  output logic [WIDTH-1:0] addr_in
);
  state_t           state, state_nx;
  logic [3:0]       cnt;
  logic             wr_q, err_q, err_c;
  logic [WIDTH-1:0] prdata_q;
  logic             setup, done;

  apb_cfg_access_check #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_chk (
    .addr       (apb.PADDR),
    .write      (apb.PWRITE),
    .ch_enabled (ch_enabled),
    .err        (err_c)
  );

  assign setup = apb.PSEL & ~apb.PENABLE;
  assign done  = (state == ACCESS) & apb.PSEL & apb.PENABLE & (cnt == 4'd0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (setup) state_nx = ACCESS;
      ACCESS:  if (!apb.PSEL) state_nx = IDLE;
               else if (apb.PENABLE && cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      cfg_data_in <= '0;
      addr_in     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && setup) begin
        addr_in     <= apb.PADDR & ~WIDTH'(3);
        cfg_data_in <= apb.PWDATA;
        wr_q        <= apb.PWRITE;
        err_q       <= err_c;
        cnt         <= 4'(WAIT_STATES);
      end
      if (state == ACCESS && apb.PSEL && apb.PENABLE) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else             prdata_q <= (!wr_q && !err_q) ? cfg_data_out : '0;
      end
    end
  end

  // Strobes are combinational so an abort or reset in the same cycle kills them.
  assign cfg_wr_en = done & ~err_q &  wr_q & ~reset;
  assign cfg_rd_en = done & ~err_q & ~wr_q & ~reset;

  assign apb.PREADY  = (state == RESP);
  assign apb.PSLVERR = (state == RESP) & err_q;
  assign apb.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb_cfg_slave.sv
// Scoreboard bench: WAIT_STATES=0 (dut 0) and WAIT_STATES=3 (dut 1).
module tb_apb_cfg_slave;
  logic        clk = 0, reset = 1;
  logic        psel = 0, penable = 0, pwrite = 0, ch_en = 0;
  logic [31:0] paddr = 0, pwdata = 0, cdo = 0;
  int          dsel = 0, cyc = 0;
  int          total = 0, bad = 0;

  logic        wr0, rd0, wr1, rd1;
  logic [31:0] di0, ai0, di1, ai1;

  apb_cfg_slave_if #(.WIDTH(32)) if0 ();
  apb_cfg_slave_if #(.WIDTH(32)) if1 ();

  assign if0.PSEL = psel & (dsel == 0);
  assign if1.PSEL = psel & (dsel == 1);
  assign if0.PENABLE = penable; assign if1.PENABLE = penable;
  assign if0.PWRITE  = pwrite;  assign if1.PWRITE  = pwrite;
  assign if0.PADDR   = paddr;   assign if1.PADDR   = paddr;
  assign if0.PWDATA  = pwdata;  assign if1.PWDATA  = pwdata;

  apb_cfg_slave #(.WIDTH(32), .ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .apb(if0), .ch_enabled(ch_en), .cfg_data_out(cdo),
    .cfg_wr_en(wr0), .cfg_rd_en(rd0), .cfg_data_in(di0), .addr_in(ai0));
  apb_cfg_slave #(.WIDTH(32), .ADDR_W(8), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(reset), .apb(if1), .ch_enabled(ch_en), .cfg_data_out(cdo),
    .cfg_wr_en(wr1), .cfg_rd_en(rd1), .cfg_data_in(di1), .addr_in(ai1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; int cyc; } strb_t;
  typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
  strb_t sq0[$], sq1[$];
  resp_t rq0[$], rq1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic wr, input logic rd, input logic rdy,
                     input logic err, input logic [31:0] a, input logic [31:0] dat,
                     input logic [31:0] rdata);
    strb_t s; resp_t r; int n;
    if (wr | rd) begin
      chk($sformatf("d%0d_strobe_excl", d), 64'(wr & rd), 0);
      n = d ? sq1.size() : sq0.size();
      if (n == 0) chk($sformatf("d%0d_spurious_strobe", d), 64'({wr, rd}), 0);
      else begin
        if (d) s = sq1.pop_front(); else s = sq0.pop_front();
        chk($sformatf("d%0d_strobe_kind", d), 64'({wr, rd}), 64'({s.wr, ~s.wr}));
        chk($sformatf("d%0d_addr_in", d), 64'(a), 64'(s.addr));
        if (s.wr) chk($sformatf("d%0d_data_in", d), 64'(dat), 64'(s.data));
        chk($sformatf("d%0d_strobe_cycle", d), 64'(cyc), 64'(s.cyc));
      end
    end
    if (rdy) begin
      n = d ? rq1.size() : rq0.size();
      if (n == 0) chk($sformatf("d%0d_spurious_pready", d), 64'(rdy), 0);
      else begin
        if (d) r = rq1.pop_front(); else r = rq0.pop_front();
        chk($sformatf("d%0d_pslverr", d), 64'(err), 64'(r.err));
        chk($sformatf("d%0d_prdata", d), 64'(rdata), 64'(r.rdata));
        chk($sformatf("d%0d_pready_cycle", d), 64'(cyc), 64'(r.cyc));
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, wr0, rd0, if0.PREADY, if0.PSLVERR, ai0, di0, if0.PRDATA);
    mon(1, wr1, rd1, if1.PREADY, if1.PSLVERR, ai1, di1, if1.PRDATA);
  end

  function automatic logic rdy(input int d);
    return d ? if1.PREADY : if0.PREADY;
  endfunction

  // Called at #1 after a rising edge; drives SETUP now, then scrambles the
  // bus during ACCESS to prove the captured values are the ones used.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] dat, input logic strobe, input logic err,
                      input logic [31:0] rdata, input logic flip);
    int ws, t0; logic got;
    ws = d ? 3 : 0;
    dsel = d; psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = dat;
    t0 = cyc;
    if (strobe) begin
      if (d) sq1.push_back('{wr, a & ~32'h3, dat, t0 + 1 + ws});
      else   sq0.push_back('{wr, a & ~32'h3, dat, t0 + 1 + ws});
    end
    if (d) rq1.push_back('{err, rdata, t0 + 2 + ws});
    else   rq0.push_back('{err, rdata, t0 + 2 + ws});
    @(posedge clk); #1;
    penable = 1; paddr = ~a; pwdata = ~dat; pwrite = ~wr;
    if (flip) ch_en = ~ch_en;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      if (rdy(d)) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) chk("pready_timeout", 64'(got), 1);
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic chk_zero(input string nm, input int d);
    if (d == 0)
      chk(nm, {wr0, rd0, if0.PREADY, if0.PSLVERR, if0.PRDATA, ai0 | di0}, 0);
    else
      chk(nm, {wr1, rd1, if1.PREADY, if1.PSLVERR, if1.PRDATA, ai1 | di1}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    chk_zero("reset_d0", 0);
    chk_zero("reset_d1", 1);
    reset = 0;
    @(posedge clk); #1;

    ch_en = 0;
    xfer(0, 1, 32'h0C, 32'h0000_1234, 1, 0, 0, 0);
    cdo = 32'hCAFE_F00D;
    xfer(0, 0, 32'h20, 0, 1, 0, 32'hCAFE_F00D, 0);
    ch_en = 1;
    xfer(0, 1, 32'h10, 32'h55, 0, 1, 0, 0);
    xfer(0, 1, 32'h04, 32'h55, 1, 0, 0, 0);
    xfer(0, 1, 32'h88, 32'hA5A5_0001, 1, 0, 0, 0);
    ch_en = 0;
    xfer(0, 1, 32'h8C, 32'h1, 0, 1, 0, 0);
    xfer(0, 1, 32'h102, 32'h2, 0, 1, 0, 0);
    xfer(0, 0, 32'h101, 0, 0, 1, 0, 0);
    xfer(0, 0, 32'h100, 0, 0, 1, 0, 0);
    xfer(0, 1, 32'hFC, 32'hDEAD_BEEF, 1, 0, 0, 0);
    xfer(0, 0, 32'h80, 0, 1, 0, 32'hCAFE_F00D, 0);
    // ch_enabled rising mid-transfer must not turn a legal write into an error.
    xfer(0, 1, 32'h10, 32'h77, 1, 0, 0, 1);
    ch_en = 0;
    xfer(0, 1, 32'h90, 32'h78, 0, 1, 0, 1);
    ch_en = 0;

    cdo = 32'h1234_5678;
    xfer(1, 0, 32'h00, 0, 1, 0, 32'h1234_5678, 0);
    xfer(1, 1, 32'h8C, 32'h9, 0, 1, 0, 0);
    xfer(1, 1, 32'h30, 32'h0BAD_F00D, 1, 0, 0, 0);

    // Abort: PSEL drops in the ACCESS cycle.
    dsel = 0; psel = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'hAA;
    @(posedge clk); #1;
    psel = 0; penable = 1;
    repeat (3) @(posedge clk); #1;
    penable = 0;
    chk("abort_pready", 64'(if0.PREADY), 0);
    xfer(0, 0, 32'h24, 0, 1, 0, 32'h1234_5678, 0);

    // Reset in the ACCESS cycle of a write.
    dsel = 0; psel = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'hBB;
    @(posedge clk); #1;
    penable = 1; reset = 1;
    @(posedge clk); #1;
    chk_zero("midreset_d0", 0);
    reset = 0; psel = 0; penable = 0;
    @(posedge clk); #1;
    cdo = 32'h0F0F_0F0F;
    xfer(0, 0, 32'h04, 0, 1, 0, 32'h0F0F_0F0F, 0);

    repeat (6) @(posedge clk); #1;
    chk("sq0_left", 64'(sq0.size()), 0);
    chk("sq1_left", 64'(sq1.size()), 0);
    chk("rq0_left", 64'(rq0.size()), 0);
    chk("rq1_left", 64'(rq1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
